// File: rtl/multi_register_bank.sv
// multi_register_bank: DEPTH x WIDTH register bank with hold/load/inc/dec write port, two read ports, carry and write-error flags
module multi_register_bank #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int ADDR_W = 2,
  parameter bit BYPASS = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [1:0]        WR_MODE,
  input  logic [WIDTH-1:0]  WR_DATA,
  input  logic [ADDR_W-1:0] RD_ADDR_A,
  output logic [WIDTH-1:0]  RD_DATA_A,
  input  logic [ADDR_W-1:0] RD_ADDR_B,
  output logic [WIDTH-1:0]  RD_DATA_B,
  output logic              CARRY,
  output logic              WR_ERR
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [WIDTH-1:0] cur, nxt, stored_a, stored_b;
  logic wr, byp, err_n, carry_n;
  always_comb begin
    hit = '0;
    cur = '0;
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = WR_MODE != 2'b00 && WR_ADDR == ADDR_W'(i);
      if (WR_ADDR == ADDR_W'(i)) cur = regs[i];
      if (RD_ADDR_A == ADDR_W'(i)) stored_a = regs[i];
      if (RD_ADDR_B == ADDR_W'(i)) stored_b = regs[i];
    end
  end
  assign wr = |hit;
  assign err_n = WR_MODE != 2'b00 && !wr;
  assign nxt = WR_MODE == 2'b01 ? WR_DATA :
               WR_MODE == 2'b10 ? cur + 1'b1 :
               WR_MODE == 2'b11 ? cur - 1'b1 : cur;
  assign carry_n = wr && WR_MODE[1] ? (WR_MODE[0] ? cur == '0 : &cur) : CARRY;
  assign byp = BYPASS && wr && !RESET;
  assign RD_DATA_A = byp && RD_ADDR_A == WR_ADDR ? nxt : stored_a;
  assign RD_DATA_B = byp && RD_ADDR_B == WR_ADDR ? nxt : stored_b;
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      CARRY <= 1'b0;
      WR_ERR <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (hit[i]) regs[i] <= nxt;
      CARRY <= carry_n;
      WR_ERR <= err_n;
    end
  end
endmodule
